// File: rtl/wb_core_arbiter.sv
// Purpose : round-robin N-master to 1-slave Wishbone-classic arbiter with
//           registered request capture, master-abort handling and watchdog.
// Latency : request sampled at edge N -> s_stb_o high after edge N; ack/err
//           pulses one cycle after the slave ack / timeout edge.
// Backpr. : one transaction in flight; other masters simply hold cyc/stb
//           until granted, and an IDLE cycle separates every transaction.
// Ports   : clk/rst_n; m_* packed per-master Wishbone inputs (slice k = port k)
//           and m_data_o/m_ack_o/m_err_o responses; s_* single slave port;
//           grant_o = index of current or last granted master.
module wb_core_arbiter #(
  parameter int NUM_PORTS      = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS-1:0]            m_cyc_i,
  input  logic [NUM_PORTS-1:0]            m_stb_i,
  input  logic [NUM_PORTS-1:0]            m_we_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] m_addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] m_data_i,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] m_data_o,
  output logic [NUM_PORTS-1:0]            m_ack_o,
  output logic [NUM_PORTS-1:0]            m_err_o,
  output logic                            s_cyc_o,
  output logic                            s_stb_o,
  output logic                            s_we_o,
  output logic [ADDR_WIDTH-1:0]           s_addr_o,
  output logic [DATA_WIDTH-1:0]           s_data_o,
  input  logic [DATA_WIDTH-1:0]           s_data_i,
  input  logic                            s_ack_i,
  output logic [((NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1)-1:0] grant_o
);

  localparam int GW      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [GW-1:0] LAST_PORT = GW'(NUM_PORTS - 1);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t                r_state;
  logic [GW-1:0]         r_last_grant;
  logic [GW-1:0]         r_grant;
  logic [CW-1:0]         r_cnt;
  logic                  r_stb;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata [NUM_PORTS];
  logic [NUM_PORTS-1:0]  r_ack;
  logic [NUM_PORTS-1:0]  r_err;

  logic [NUM_PORTS-1:0]  w_req;
  logic                  w_found;
  logic [GW-1:0]         w_sel;
  logic [GW-1:0]         w_idx;
  logic [ADDR_WIDTH-1:0] w_addr  [NUM_PORTS];
  logic [DATA_WIDTH-1:0] w_wdata [NUM_PORTS];

  assign w_req = m_cyc_i & m_stb_i;

  always_comb begin
    for (int k = 0; k < NUM_PORTS; k++) begin
      w_addr[k]  = m_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
      w_wdata[k] = m_data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Walk from the farthest offset to the nearest so the last hit (the port
  // right after last_grant) is the one that sticks.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      w_idx = GW'((int'(r_last_grant) + i) % NUM_PORTS);
      if (w_req[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_last_grant <= LAST_PORT;
      r_grant      <= '0;
      r_cnt        <= '0;
      r_stb        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_ack        <= '0;
      r_err        <= '0;
      for (int k = 0; k < NUM_PORTS; k++) r_rdata[k] <= '0;
    end else begin
      r_ack <= '0;
      r_err <= '0;
      case (r_state)
        ST_IDLE: begin
          // A late s_ack_i here is deliberately ignored.
          if (w_found) begin
            r_we         <= m_we_i[w_sel];
            r_addr       <= w_addr[w_sel];
            r_wdata      <= w_wdata[w_sel];
            r_stb        <= 1'b1;
            r_grant      <= w_sel;
            r_last_grant <= w_sel;
            r_cnt        <= '0;
            r_state      <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (s_ack_i) begin
            r_rdata[r_grant] <= s_data_i;
            r_ack[r_grant]   <= 1'b1;
            r_stb            <= 1'b0;
            r_state          <= ST_IDLE;
          end else if (!m_cyc_i[r_grant]) begin
            r_stb   <= 1'b0;
            r_state <= ST_IDLE;
          end else if ((TIMEOUT_CYCLES != 0) && (r_cnt == CW'(TO_LAST))) begin
            r_err[r_grant] <= 1'b1;
            r_stb          <= 1'b0;
            r_state        <= ST_IDLE;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_PORTS; k++) m_data_o[k*DATA_WIDTH +: DATA_WIDTH] = r_rdata[k];
  end

  assign m_ack_o  = r_ack;
  assign m_err_o  = r_err;
  assign s_cyc_o  = r_stb;
  assign s_stb_o  = r_stb;
  assign s_we_o   = r_we;
  assign s_addr_o = r_addr;
  assign s_data_o = r_wdata;
  assign grant_o  = r_grant;

endmodule

// File: tb/tb_wb_core_arbiter.sv
// Purpose : directed scoreboard bench for wb_core_arbiter (2 ports, timeout 8).
// Latency : expected slave requests/responses queued at stimulus time, popped
//           by a negedge monitor when the DUT presents them.
// Backpr. : bench masters hold cyc/stb until ack/err or a scripted abort.
module tb_wb_core_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  m_cyc_i, m_stb_i, m_we_i;
  logic [63:0] m_addr_i, m_data_i;
  logic [63:0] m_data_o;
  logic [1:0]  m_ack_o, m_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_addr_o, s_data_o, s_data_i;
  logic        s_ack_i;
  logic [0:0]  grant_o;

  logic        slave_ack, man_ack;
  int          slave_lat;
  logic [31:0] key;

  assign s_ack_i = slave_ack | man_ack;

  wb_core_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_addr_i(m_addr_i), .m_data_i(m_data_i), .m_data_o(m_data_o),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_data_i(s_data_i),
    .s_ack_i(s_ack_i), .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  typedef struct { int port; logic we; logic [31:0] addr; logic [31:0] wdata; int dur; int gap; } req_t;
  typedef struct { int port; int kind; logic [31:0] data; } rsp_t;
  typedef struct { logic we; logic [31:0] addr; logic [31:0] data; logic [31:0] addr2; int chg_n; int abort_n; } job_t;

  req_t exp_req[$];
  rsp_t exp_rsp[$];
  job_t jq0[$];
  job_t jq1[$];
  logic [31:0] exp_rdata [2];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add_job(input int p, input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] a2, input int chg_n, input int abort_n);
    job_t j;
    j.we = we; j.addr = a; j.data = d; j.addr2 = a2; j.chg_n = chg_n; j.abort_n = abort_n;
    if (p == 0) jq0.push_back(j); else jq1.push_back(j);
  endtask

  // kind: 0 no response, 1 ack carrying rdata, 2 err (slice keeps its value)
  task automatic expect_txn(input int p, input logic we, input logic [31:0] a, input logic [31:0] wd,
                            input int dur, input int gap, input int kind, input logic [31:0] rdata);
    req_t r;
    rsp_t s;
    r.port = p; r.we = we; r.addr = a; r.wdata = wd; r.dur = dur; r.gap = gap;
    exp_req.push_back(r);
    if (kind == 1) exp_rdata[p] = rdata;
    if (kind != 0) begin
      s.port = p; s.kind = kind; s.data = exp_rdata[p];
      exp_rsp.push_back(s);
    end
  endtask

  // Masters: both ports handled by one process.
  logic [1:0] act;
  int         mn [2];
  job_t       mj [2];

  initial begin
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0; m_addr_i = '0; m_data_i = '0; act = '0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (act[k]) begin
          mn[k]++;
          if (m_ack_o[k] || m_err_o[k]) act[k] = 1'b0;
          else if (mj[k].abort_n != 0 && mn[k] == mj[k].abort_n) act[k] = 1'b0;
          else if (mj[k].chg_n != 0 && mn[k] == mj[k].chg_n) begin
            m_addr_i[k*32 +: 32] = mj[k].addr2;
            m_data_i[k*32 +: 32] = ~mj[k].data;
          end else if (mn[k] > 300) act[k] = 1'b0;
        end
        if (!act[k]) begin
          if ((k == 0 && jq0.size() > 0) || (k == 1 && jq1.size() > 0)) begin
            if (k == 0) mj[k] = jq0.pop_front(); else mj[k] = jq1.pop_front();
            act[k] = 1'b1;
            mn[k]  = 0;
            m_cyc_i[k] = 1'b1;
            m_stb_i[k] = 1'b1;
            m_we_i[k]  = mj[k].we;
            m_addr_i[k*32 +: 32] = mj[k].addr;
            m_data_i[k*32 +: 32] = mj[k].data;
          end else begin
            m_cyc_i[k] = 1'b0;
            m_stb_i[k] = 1'b0;
          end
        end
      end
    end
  end

  // Slave: acks once s_stb_o has been high slave_lat cycles (0 = never).
  initial begin
    int age;
    age = 0; slave_ack = 1'b0; s_data_i = '0;
    forever begin
      @(negedge clk);
      if (s_stb_o) age++; else age = 0;
      s_data_i  = s_addr_o ^ key;
      slave_ack = (slave_lat != 0) && (age == slave_lat);
    end
  end

  // Monitor
  logic prev_stb = 1'b0;
  logic in_txn   = 1'b0;
  int   hi_cnt   = 0;
  int   low_cnt  = 0;
  req_t cur;

  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_txn = 1'b0; prev_stb = 1'b0; low_cnt = 0;
      end else begin
        if (s_stb_o && !prev_stb) begin
          if (exp_req.size() == 0) chk("unexpected_req", {31'd0, s_stb_o}, 64'd0);
          else begin
            cur = exp_req.pop_front();
            in_txn = 1'b1;
            hi_cnt = 0;
            if (cur.gap >= 0) chk("idle_gap", low_cnt, cur.gap);
          end
        end
        if (s_stb_o && in_txn) begin
          hi_cnt++;
          chk("grant", grant_o, cur.port);
          chk("s_we", s_we_o, cur.we);
          chk("s_addr", s_addr_o, cur.addr);
          chk("s_data", s_data_o, cur.wdata);
          chk("s_cyc", s_cyc_o, 1);
        end
        if (!s_stb_o && prev_stb && in_txn) begin
          chk("stb_cycles", hi_cnt, cur.dur);
          in_txn = 1'b0;
        end
        if (!s_stb_o) low_cnt = (prev_stb) ? 1 : low_cnt + 1;
        if (m_ack_o != 2'b00 || m_err_o != 2'b00) begin
          if (exp_rsp.size() == 0) chk("unexpected_rsp", {m_ack_o, m_err_o}, 64'd0);
          else begin
            r = exp_rsp.pop_front();
            chk("m_ack", m_ack_o, (r.kind == 1) ? (2'b01 << r.port) : 2'b00);
            chk("m_err", m_err_o, (r.kind == 2) ? (2'b01 << r.port) : 2'b00);
            chk("m_data", m_data_o[r.port*32 +: 32], r.data);
          end
        end
        prev_stb = s_stb_o;
      end
    end
  end

  task automatic wait_idle(input int budget);
    int t = 0;
    while ((jq0.size() + jq1.size() + exp_req.size() + exp_rsp.size() != 0 || act != 2'b00 || in_txn)
           && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("drain_in_budget", t < budget, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_s_cyc_stb_we"}, {s_cyc_o, s_stb_o, s_we_o}, 0);
    chk({tag, "_s_addr"}, s_addr_o, 0);
    chk({tag, "_s_data"}, s_data_o, 0);
    chk({tag, "_ack_err"}, {m_ack_o, m_err_o}, 0);
    chk({tag, "_grant"}, grant_o, 0);
    chk({tag, "_m_data"}, m_data_o, 0);
  endtask

  initial begin
    rst_n = 1'b0; man_ack = 1'b0; slave_lat = 0; key = '0;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    #12;
    check_reset_state("reset");
    @(negedge clk); rst_n = 1'b1;

    // Single read on port 1, slave acks after 3 cycles.
    @(posedge clk);
    slave_lat = 3; key = 32'hDEADBEAF;
    add_job(1, 1'b0, 32'h40, 32'h0, 32'h0, 0, 0);
    expect_txn(1, 1'b0, 32'h40, 32'h0, 3, -1, 1, 32'hDEADBEEF);
    wait_idle(100);
    chk("read_slice0_untouched", m_data_o[31:0], 32'h0);

    // Contention: both ports twice, alternating grants.
    @(posedge clk);
    slave_lat = 1; key = 32'h5A5A_0000;
    add_job(0, 1'b0, 32'h1000, 32'h0, 32'h0, 0, 0);
    add_job(0, 1'b0, 32'h1004, 32'h0, 32'h0, 0, 0);
    add_job(1, 1'b0, 32'h2000, 32'h0, 32'h0, 0, 0);
    add_job(1, 1'b0, 32'h2004, 32'h0, 32'h0, 0, 0);
    expect_txn(0, 1'b0, 32'h1000, 32'h0, 1, -1, 1, 32'h5A5A_1000);
    expect_txn(1, 1'b0, 32'h2000, 32'h0, 1, 1, 1, 32'h5A5A_2000);
    expect_txn(0, 1'b0, 32'h1004, 32'h0, 1, 1, 1, 32'h5A5A_1004);
    expect_txn(1, 1'b0, 32'h2004, 32'h0, 1, 1, 1, 32'h5A5A_2004);
    wait_idle(200);

    // Write capture: master changes addr/data while busy.
    @(posedge clk);
    slave_lat = 3; key = 32'h0BAD_0000;
    add_job(0, 1'b1, 32'h100, 32'h12345678, 32'h200, 1, 0);
    expect_txn(0, 1'b1, 32'h100, 32'h12345678, 3, -1, 1, 32'h0BAD_0100);
    wait_idle(100);

    // Timeout: slave never acks.
    @(posedge clk);
    slave_lat = 0;
    add_job(0, 1'b0, 32'h300, 32'h0, 32'h0, 0, 0);
    expect_txn(0, 1'b0, 32'h300, 32'h0, 8, -1, 2, 32'h0);
    wait_idle(100);

    // Late ack while idle must be ignored.
    @(negedge clk); man_ack = 1'b1;
    repeat (2) @(negedge clk);
    man_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("late_ack_data", m_data_o, {exp_rdata[1], exp_rdata[0]});
    chk("late_ack_idle", s_stb_o, 0);

    // Master abort on port 1 after two busy cycles.
    @(posedge clk);
    add_job(1, 1'b0, 32'h400, 32'h0, 32'h0, 0, 2);
    expect_txn(1, 1'b0, 32'h400, 32'h0, 2, -1, 0, 32'h0);
    wait_idle(100);

    // Ack lands on the timeout cycle: ack only.
    @(posedge clk);
    slave_lat = 8;
    add_job(0, 1'b0, 32'h500, 32'h0, 32'h0, 0, 0);
    expect_txn(0, 1'b0, 32'h500, 32'h0, 8, -1, 1, 32'h0BAD_0500);
    wait_idle(100);

    // Async reset while port 1 is busy.
    @(posedge clk);
    slave_lat = 0;
    add_job(1, 1'b0, 32'h800, 32'h55, 32'h0, 0, 4);
    expect_txn(1, 1'b0, 32'h800, 32'h55, 0, -1, 0, 32'h0);
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", {s_stb_o, grant_o}, 2'b11);
    #2 rst_n = 1'b0;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    #1 check_reset_state("mid_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Priority restarts at port 0.
    @(posedge clk);
    slave_lat = 2; key = 32'h7777_0000;
    add_job(0, 1'b0, 32'h600, 32'h0, 32'h0, 0, 0);
    add_job(1, 1'b0, 32'h700, 32'h0, 32'h0, 0, 0);
    expect_txn(0, 1'b0, 32'h600, 32'h0, 2, -1, 1, 32'h7777_0600);
    expect_txn(1, 1'b0, 32'h700, 32'h0, 2, 1, 1, 32'h7777_0700);
    wait_idle(100);

    chk("req_queue_empty", exp_req.size(), 0);
    chk("rsp_queue_empty", exp_rsp.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
